// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b type definitions used by the memory responder and its storage array.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_responder_array.sv
// Word storage with byte-lane write enables and a registered synchronous read port.
module mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  lc3b_mem_wmask        wmask,
  input  logic [ADDR_BITS-1:0] waddr,
  input  lc3b_word             wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output lc3b_word             rdata
);

  lc3b_word mem [2**ADDR_BITS];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[waddr][7:0]  <= wdata[7:0];
      if (wmask[1]) mem[waddr][15:8] <= wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory port: latches a request, waits DELAY
// cycles, then pulses mem_resp for one cycle with read data or a completed write.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int DELAY     = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata
);

  // Handshake: mem_read/mem_write are held by the initiator until mem_resp, which is a
  // single-cycle pulse; requests seen while in DONE are ignored, a request still held
  // in the following IDLE cycle begins a new transaction.

  lc3b_memresp_state    state, state_next;
  logic [3:0]           count, count_next;
  logic                 load, rd_en;
  logic                 op_write;
  logic [ADDR_BITS-1:0] idx, raddr;
  lc3b_word             wdata_q;
  lc3b_mem_wmask        wmask_q;
  logic                 resp_q;
  logic                 unused_addr;

  assign unused_addr = ^{mem_address[0], mem_address >> (ADDR_BITS + 1)};

  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read | mem_write) begin
          load       = 1'b1;
          count_next = 4'(DELAY - 1);
          if (DELAY == 1) begin
            state_next = DONE;
            rd_en      = ~mem_write;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        count_next = count - 4'd1;
        // Leave when the decremented count reaches zero so DONE lands DELAY cycles
        // after acceptance.
        if (count <= 4'd1) begin
          count_next = 4'd0;
          state_next = DONE;
          rd_en      = ~op_write;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      resp_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      resp_q <= (state_next == DONE);
      if (load) begin
        op_write <= mem_write;
        idx      <= mem_address[ADDR_BITS:1];
        wdata_q  <= mem_wdata;
        wmask_q  <= mem_byte_enable;
      end
    end
  end

  // With DELAY = 1 the read happens on the acceptance edge, before idx is loaded.
  assign raddr = (state == IDLE) ? mem_address[ADDR_BITS:1] : idx;

  mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    ((state == DONE) && op_write && !reset),
    .wmask (wmask_q),
    .waddr (idx),
    .wdata (wdata_q),
    .re    (rd_en && !reset),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  assign mem_resp = resp_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: DELAY=3 and DELAY=1 instances, scoreboard of
// expected response cycle and read data checked by per-instance monitors.
module tb_lc3b_mem_responder;

  localparam int D0 = 3;
  localparam int D1 = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  logic [1:0]  be0 = 0, be1 = 0;
  logic [15:0] addr0 = 0, wd0 = 0, addr1 = 0, wd1 = 0;
  logic        resp0, resp1;
  logic [15:0] rdata0, rdata1;

  lc3b_mem_responder #(.DELAY(D0), .ADDR_BITS(8)) dut0 (
    .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0),
    .mem_byte_enable(be0), .mem_address(addr0), .mem_wdata(wd0),
    .mem_resp(resp0), .mem_rdata(rdata0)
  );

  lc3b_mem_responder #(.DELAY(D1), .ADDR_BITS(8)) dut1 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1),
    .mem_byte_enable(be1), .mem_address(addr1), .mem_wdata(wd1),
    .mem_resp(resp1), .mem_rdata(rdata1)
  );

  // scoreboard: {expected resp cycle, expected mem_rdata}
  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];
  logic [47:0] e0, e1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_resp: got resp in cycle %0d expected none", cyc);
      end else begin
        e0 = exp_q0.pop_front();
        cmp("dut0_resp_cycle", cyc, e0[47:16]);
        cmp("dut0_rdata", {16'h0, rdata0}, {16'h0, e0[15:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (resp1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_resp: got resp in cycle %0d expected none", cyc);
      end else begin
        e1 = exp_q1.pop_front();
        cmp("dut1_resp_cycle", cyc, e1[47:16]);
        cmp("dut1_rdata", {16'h0, rdata1}, {16'h0, e1[15:0]});
      end
    end
  end

  // driver tasks
  task automatic drive(input bit sel, input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input logic [1:0] be);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = data; be1 = be;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = addr; wd0 = data; be0 = be;
    end
  endtask

  // Issues a request, expects nresp pulses each returning exp_rd, holds the request
  // until the last pulse; chg swaps the address in the first cycle after issue.
  task automatic txn(input bit sel, input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [15:0] data, input logic [1:0] be, input int nresp,
                     input logic [15:0] exp_rd, input bit chg, input logic [15:0] addr2);
    int dly;
    int seen;
    int guard;
    logic [31:0] c;
    dly = sel ? D1 : D0;
    @(negedge clk);
    drive(sel, rd, wr, addr, data, be);
    c = cyc;
    for (int k = 0; k < nresp; k++) begin
      if (sel) exp_q1.push_back({32'(c + dly + k * (dly + 1)), exp_rd});
      else     exp_q0.push_back({32'(c + dly + k * (dly + 1)), exp_rd});
    end
    seen  = 0;
    guard = 0;
    while (seen < nresp && guard < 64) begin
      @(negedge clk);
      guard++;
      if (guard == 1 && chg) drive(sel, rd, wr, addr2, data, be);
      if (sel ? resp1 : resp0) seen++;
    end
    if (seen < nresp) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", seen, nresp);
    end
    drive(sel, 1'b0, 1'b0, addr, data, be);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cmp("reset_resp0", {31'h0, resp0}, 32'h0);
    cmp("reset_rdata0", {16'h0, rdata0}, 32'h0);
    cmp("reset_resp1", {31'h0, resp1}, 32'h0);
    cmp("reset_rdata1", {16'h0, rdata1}, 32'h0);

    // word round-trip
    txn(0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, 1, 16'h0000, 0, 16'h0);
    txn(0, 1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'hBEEF, 0, 16'h0);

    // byte lanes
    txn(0, 0, 1, 16'h0011, 16'h1234, 2'b01, 1, 16'hBEEF, 0, 16'h0);
    txn(0, 1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'hBE34, 0, 16'h0);
    txn(0, 0, 1, 16'h0010, 16'h5600, 2'b10, 1, 16'hBE34, 0, 16'h0);
    txn(0, 1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'h5634, 0, 16'h0);
    txn(0, 0, 1, 16'h0010, 16'hFFFF, 2'b00, 1, 16'h5634, 0, 16'h0);
    txn(0, 1, 0, 16'h0010, 16'h0000, 2'b00, 1, 16'h5634, 0, 16'h0);

    // aliasing, mid-BUSY address change, held request
    txn(0, 0, 1, 16'h0202, 16'hA5A5, 2'b11, 1, 16'h5634, 0, 16'h0);
    txn(0, 1, 0, 16'h0002, 16'h0000, 2'b00, 1, 16'hA5A5, 0, 16'h0);
    txn(0, 1, 0, 16'h0002, 16'h0000, 2'b00, 1, 16'hA5A5, 1, 16'h0010);
    txn(0, 1, 0, 16'h0002, 16'h0000, 2'b00, 2, 16'hA5A5, 0, 16'h0);

    // read/write conflict resolves to a write
    txn(0, 1, 1, 16'h0020, 16'h0F0F, 2'b11, 1, 16'hA5A5, 0, 16'h0);
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 1, 16'h0F0F, 0, 16'h0);

    // reset in DONE suppresses the write
    txn(0, 0, 1, 16'h0030, 16'h1111, 2'b11, 1, 16'h0F0F, 0, 16'h0);
    txn(0, 0, 1, 16'h0030, 16'h2222, 2'b11, 1, 16'h0F0F, 0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp("rdata_after_done_reset", {16'h0, rdata0}, 32'h0);
    repeat (8) @(negedge clk);
    txn(0, 1, 0, 16'h0030, 16'h0000, 2'b00, 1, 16'h1111, 0, 16'h0);

    // reset in BUSY abandons the transaction
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0030, 16'h2222, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0030, 16'h2222, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    cmp("rdata_after_busy_reset", {16'h0, rdata0}, 32'h0);
    repeat (8) @(negedge clk);
    txn(0, 1, 0, 16'h0030, 16'h0000, 2'b00, 1, 16'h1111, 0, 16'h0);

    // DELAY = 1 instance
    txn(1, 0, 1, 16'h0004, 16'h7777, 2'b11, 1, 16'h0000, 0, 16'h0);
    txn(1, 1, 0, 16'h0004, 16'h0000, 2'b00, 3, 16'h7777, 0, 16'h0);

    repeat (10) @(negedge clk);
    cmp("dut0_queue_drained", exp_q0.size(), 32'h0);
    cmp("dut1_queue_drained", exp_q1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
